// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: groups the two master request ports, the shared
// decoder-side bus and the status/control lines of mem_bus_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of
// the environment around it (CPU, DMA engine and address decoder).
interface mem_bus_arbiter_if;
    logic        m0_valid;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    logic [1:0]  grant;
    logic        timeout_err;
    logic        err_clear;

    modport master (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  bus_rdata, bus_ready, err_clear,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output bus_valid, bus_addr, bus_wdata, bus_wstrb,
        output grant, timeout_err
    );

    modport slave (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output bus_rdata, bus_ready, err_clear,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
        input  grant, timeout_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter between the CPU (master 0) and the
// DMA engine (master 1) for the single valid/ready memory bus feeding the
// address decoder. One transaction per grant. Every completion is followed
// by one idle cycle so that the decoder's registered ready can fall.
// Optional watchdog: define BUS_TIMEOUT_EN to abort transactions that are
// not answered within TIMEOUT_CYCLES granted cycles. An aborted transaction
// completes with rdata 0 and sets the sticky timeout_err flag.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_bus_arbiter_if.master    bus
);

`ifdef BUS_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1
    } state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic [1:0]  grant_reg;
    logic [1:0]  grant_next;
    logic        last_reg;
    logic        last_next;

    logic        owner;
    logic        owner_valid;
    logic [31:0] owner_addr;
    logic [31:0] owner_wdata;
    logic [3:0]  owner_wstrb;

    // The owner is master 1 when grant bit 1 is set, otherwise master 0.
    assign owner       = grant_reg[1];
    assign owner_valid = owner ? bus.m1_valid : bus.m0_valid;
    assign owner_addr  = owner ? bus.m1_addr  : bus.m0_addr;
    assign owner_wdata = owner ? bus.m1_wdata : bus.m0_wdata;
    assign owner_wstrb = owner ? bus.m1_wstrb : bus.m0_wstrb;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_reg;
    logic             err_next;
    logic             at_limit;

    assign at_limit        = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = err_reg;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            err_reg <= err_next;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_err_clear;

    assign unused_err_clear = bus.err_clear;
    assign bus.timeout_err  = 1'b0;
`endif

    // State, owner and round-robin history registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant_reg <= 2'b00;
            last_reg  <= 1'b1;
        end else begin
            state     <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/abandon/timeout in BUSY.
    always_comb begin
        state_next = state;
        grant_next = grant_reg;
        last_next  = last_reg;
`ifdef BUS_TIMEOUT_EN
        cnt_next   = cnt;
        err_next   = err_reg;
        if (bus.err_clear) begin
            err_next = 1'b0;
        end
`endif
        case (state)
            IDLE: begin
`ifdef BUS_TIMEOUT_EN
                cnt_next = '0;
`endif
                if (bus.m0_valid && bus.m1_valid) begin
                    grant_next = last_reg ? 2'b01 : 2'b10;
                    state_next = BUSY;
                end else if (bus.m0_valid) begin
                    grant_next = 2'b01;
                    state_next = BUSY;
                end else if (bus.m1_valid) begin
                    grant_next = 2'b10;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.bus_ready) begin
                    last_next  = owner;
                    grant_next = 2'b00;
                    state_next = IDLE;
                end else if (!owner_valid) begin
                    grant_next = 2'b00;
                    state_next = IDLE;
`ifdef BUS_TIMEOUT_EN
                end else if (at_limit) begin
                    state_next = ABORT;
                end else begin
                    cnt_next = cnt + 1'b1;
`endif
                end
            end
`ifdef BUS_TIMEOUT_EN
            ABORT: begin
                err_next   = 1'b1;
                last_next  = owner;
                grant_next = 2'b00;
                state_next = IDLE;
            end
`endif
            default: begin
                grant_next = 2'b00;
                state_next = IDLE;
            end
        endcase
    end

    // Bus and master-side outputs: the owner sees the decoder, the other master sees zeros.
    always_comb begin
        bus.grant     = grant_reg;
        bus.bus_valid = 1'b0;
        bus.bus_addr  = 32'h0;
        bus.bus_wdata = 32'h0;
        bus.bus_wstrb = 4'h0;
        bus.m0_ready  = 1'b0;
        bus.m0_rdata  = 32'h0;
        bus.m1_ready  = 1'b0;
        bus.m1_rdata  = 32'h0;
        case (state)
            BUSY: begin
                bus.bus_valid = owner_valid;
                bus.bus_addr  = owner_addr;
                bus.bus_wdata = owner_wdata;
                bus.bus_wstrb = owner_wstrb;
                if (owner) begin
                    bus.m1_ready = bus.bus_ready;
                    bus.m1_rdata = bus.bus_rdata;
                end else begin
                    bus.m0_ready = bus.bus_ready;
                    bus.m0_rdata = bus.bus_rdata;
                end
            end
`ifdef BUS_TIMEOUT_EN
            ABORT: begin
                bus.bus_addr  = owner_addr;
                bus.bus_wdata = owner_wdata;
                bus.bus_wstrb = owner_wstrb;
                if (owner) begin
                    bus.m1_ready = 1'b1;
                end else begin
                    bus.m0_ready = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven vectors for the directed scenarios, a
// randomized phase against a transaction-level reference model, and
// watchdog sequences when BUS_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_mem_bus_arbiter;

    typedef struct {
        logic        rn;
        logic        v0;
        logic        v1;
        logic        br;
        logic [31:0] brd;
        logic        clr;
        logic [1:0]  g;
        logic        bv;
        logic        r0;
        logic        r1;
        logic        ab;
        logic        err;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mem_bus_arbiter_if bif ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rn, logic v0, logic v1, logic br, logic [31:0] brd,
                                logic clr, logic [1:0] g, logic bv, logic r0, logic r1,
                                logic ab, logic err);
        vec_t v;
        v.rn = rn; v.v0 = v0; v.v1 = v1; v.br = br; v.brd = brd; v.clr = clr;
        v.g = g; v.bv = bv; v.r0 = r0; v.r1 = r1; v.ab = ab; v.err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        @(posedge clk);
        #1;
        reset_n       = v.rn;
        bif.m0_valid  = v.v0;
        bif.m1_valid  = v.v1;
        bif.bus_ready = v.br;
        bif.bus_rdata = v.brd;
        bif.err_clear = v.clr;
    endtask

    task automatic checkOutput(vec_t e, string tag);
        logic [31:0] ea, ed, rd0, rd1;
        logic [3:0]  es;
        ea = 32'h0; ed = 32'h0; es = 4'h0;
        if (e.g == 2'b01) begin
            ea = bif.m0_addr; ed = bif.m0_wdata; es = bif.m0_wstrb;
        end else if (e.g == 2'b10) begin
            ea = bif.m1_addr; ed = bif.m1_wdata; es = bif.m1_wstrb;
        end
        rd0 = (e.g[0] && !e.ab) ? e.brd : 32'h0;
        rd1 = (e.g[1] && !e.ab) ? e.brd : 32'h0;
        check({tag, " grant"},     32'(bif.grant),     32'(e.g));
        check({tag, " bus_valid"}, 32'(bif.bus_valid), 32'(e.bv));
        if (!e.ab) begin
            check({tag, " bus_addr"},  bif.bus_addr,         ea);
            check({tag, " bus_wdata"}, bif.bus_wdata,        ed);
            check({tag, " bus_wstrb"}, 32'(bif.bus_wstrb),   32'(es));
        end
        check({tag, " m0_ready"},    32'(bif.m0_ready),    32'(e.r0));
        check({tag, " m1_ready"},    32'(bif.m1_ready),    32'(e.r1));
        check({tag, " m0_rdata"},    bif.m0_rdata,         rd0);
        check({tag, " m1_rdata"},    bif.m1_rdata,         rd1);
        check({tag, " timeout_err"}, 32'(bif.timeout_err), 32'(e.err));
    endtask

    task automatic runVec(vec_t v, string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
    endtask

    // Global time bound so the bench always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the test completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        tbl[$];
        bit          pend[2];
        bit          got[2];
        logic [31:0] a[2];
        logic [31:0] d[2];
        logic [3:0]  s[2];
        bit          prev_bv, prev_br, br;
        int          slv_cnt, slv_dly, own, lst, mdl_done, dut_done;
        vec_t        e;

        checks = 0;
        errors = 0;
        reset_n       = 1'b0;
        bif.m0_valid  = 1'b0;
        bif.m1_valid  = 1'b0;
        bif.m0_addr   = 32'hC300_0004;
        bif.m0_wdata  = 32'h0102_0304;
        bif.m0_wstrb  = 4'h0;
        bif.m1_addr   = 32'hD000_0010;
        bif.m1_wdata  = 32'hDEAD_BEEF;
        bif.m1_wstrb  = 4'hF;
        bif.bus_ready = 1'b0;
        bif.bus_rdata = 32'h0;
        bif.err_clear = 1'b0;
        repeat (2) @(posedge clk);

        //           rn v0 v1 br brd            clr g      bv r0 r1 ab err
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0)); // reset state
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0)); // m0 read c0
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 2'b01, 1, 0, 0, 0, 0)); // c1
        tbl.push_back(mk(1, 1, 0, 1, 32'h1234_5678,0, 2'b01, 1, 1, 0, 0, 0)); // c2 ready
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0)); // c3 idle
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0)); // tie c0
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,        0, 2'b01, 1, 0, 0, 0, 0)); // c1 m0 wins
        tbl.push_back(mk(1, 1, 1, 1, 32'hAAAA_0000,0, 2'b01, 1, 1, 0, 0, 0)); // c2 m0 done
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0)); // c3 idle
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 2'b10, 1, 0, 0, 0, 0)); // c4 m1 write
        tbl.push_back(mk(1, 0, 1, 1, 32'h5555_0000,0, 2'b10, 1, 0, 1, 0, 0)); // c5 m1 done
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0)); // both held
        tbl.push_back(mk(1, 1, 1, 1, 32'h1111_1111,0, 2'b01, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 32'h2222_2222,0, 2'b10, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,        0, 2'b01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 2'b01, 0, 0, 0, 0, 0)); // m0 abandons
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0)); // last still m1
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 2'b01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 2'b01, 1, 0, 0, 0, 0)); // reset mid-txn
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 2'b10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 32'hCAFE_F00D,0, 2'b10, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 2'b00, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            runVec(tbl[i], $sformatf("vec%0d", i));
        end

        // Randomized traffic: masters hold requests until ready, the slave
        // answers a random 1..4 cycles after it sees bus_valid.
        pend = '{0, 0}; got = '{0, 0};
        a = '{32'h0, 32'h0}; d = '{32'h0, 32'h0}; s = '{4'h0, 4'h0};
        prev_bv = 0; prev_br = 0; slv_cnt = 0; slv_dly = 0;
        own = -1; lst = 1; mdl_done = 0; dut_done = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (pend[m] && got[m]) pend[m] = 0;
                if (!pend[m] && $urandom_range(2) == 0) begin
                    pend[m] = 1;
                    a[m] = $urandom;
                    d[m] = $urandom;
                    s[m] = 4'($urandom_range(15));
                end
            end
            br = 0;
            if (prev_bv && !prev_br) begin
                if (slv_cnt >= slv_dly) begin
                    br = 1;
                    slv_cnt = 0;
                    slv_dly = $urandom_range(3);
                end else begin
                    slv_cnt++;
                end
            end else begin
                slv_cnt = 0;
            end

            e = mk(1, pend[0], pend[1], br, $urandom, 0, 2'b00, 0, 0, 0, 0, 0);
            if (own >= 0) begin
                e.g  = (own == 1) ? 2'b10 : 2'b01;
                e.bv = pend[own];
                if (own == 0) e.r0 = br;
                else          e.r1 = br;
            end

            applyStimulus(e);
            bif.m0_addr = a[0]; bif.m0_wdata = d[0]; bif.m0_wstrb = s[0];
            bif.m1_addr = a[1]; bif.m1_wdata = d[1]; bif.m1_wstrb = s[1];
            @(negedge clk);
            checkOutput(e, $sformatf("rnd%0d", cyc));
            got[0]  = bif.m0_ready;
            got[1]  = bif.m1_ready;
            if (bif.m0_ready || bif.m1_ready) dut_done++;
            prev_bv = bif.bus_valid;
            prev_br = br;

            if (own < 0) begin
                if (pend[0] && pend[1]) own = 1 - lst;
                else if (pend[0])       own = 0;
                else if (pend[1])       own = 1;
            end else if (br) begin
                mdl_done++;
                lst = own;
                own = -1;
            end else if (!pend[own]) begin
                own = -1;
            end
        end
        check("rnd completions", 32'(dut_done), 32'(mdl_done));

`ifdef BUS_TIMEOUT_EN
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 0));
        bif.m0_addr = 32'hC300_0004; bif.m0_wdata = 32'h0; bif.m0_wstrb = 4'h0;
        bif.m1_addr = 32'hD000_0010; bif.m1_wdata = 32'h0; bif.m1_wstrb = 4'h0;

        // Stalled slave: abort at cycle 9, sticky error until cleared.
        runVec(mk(1, 1, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 0), "toA c0");
        for (int c = 1; c <= 8; c++)
            runVec(mk(1, 1, 0, 0, 32'h5A5A_5A5A, 0, 2'b01, 1, 0, 0, 0, 0), $sformatf("toA c%0d", c));
        runVec(mk(1, 1, 0, 0, 32'h5A5A_5A5A, 0, 2'b01, 0, 1, 0, 1, 0), "toA c9");
        runVec(mk(1, 0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 1), "toA c10");
        runVec(mk(1, 0, 0, 0, 32'h0, 1, 2'b00, 0, 0, 0, 0, 1), "toA c11");
        runVec(mk(1, 0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 0), "toA c12");

        // Slave answers exactly at the limit cycle: normal completion.
        runVec(mk(1, 1, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 0), "toB c0");
        for (int c = 1; c <= 7; c++)
            runVec(mk(1, 1, 0, 0, 32'h0, 0, 2'b01, 1, 0, 0, 0, 0), $sformatf("toB c%0d", c));
        runVec(mk(1, 1, 0, 1, 32'h0BAD_CAFE, 0, 2'b01, 1, 1, 0, 0, 0), "toB c8");
        runVec(mk(1, 0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 0), "toB c9");
        runVec(mk(1, 0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 0), "toB c10");

        // Set and clear in the same cycle: set wins; late bus_ready in abort is ignored.
        runVec(mk(1, 0, 1, 0, 32'h0, 1, 2'b00, 0, 0, 0, 0, 0), "toC c0");
        for (int c = 1; c <= 8; c++)
            runVec(mk(1, 0, 1, 0, 32'h0, 1, 2'b10, 1, 0, 0, 0, 0), $sformatf("toC c%0d", c));
        runVec(mk(1, 0, 1, 1, 32'hFFFF_FFFF, 1, 2'b10, 0, 0, 1, 1, 0), "toC c9");
        runVec(mk(1, 0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 1), "toC c10");
        runVec(mk(1, 0, 0, 0, 32'h0, 1, 2'b00, 0, 0, 0, 0, 1), "toC c11");
        runVec(mk(1, 0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 0), "toC c12");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
